// File: rtl/dm_sched_pkg.sv
// Shared definitions for the DataMover command scheduler: command/status field
// layout, register map, FSM states and the command-word builder.
package dm_sched_pkg;

    localparam int CMD_W  = 72;
    localparam int STS_W  = 8;
    localparam int BTT_W  = 23;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 4;

    localparam int CMD_BTT_LSB  = 0;
    localparam int CMD_INCR_BIT = 23;
    localparam int CMD_EOF_BIT  = 30;
    localparam int CMD_ADDR_LSB = 32;
    localparam int CMD_TAG_LSB  = 64;

    localparam int STS_OKAY_BIT = 7;
    localparam int STS_TAG_LSB  = 0;

    localparam int PUSH_EOF_BIT = 30;

    localparam int STSR_VALID_BIT = 8;
    localparam int STSR_ERR_BIT   = 9;
    localparam int STSR_TMO_BIT   = 10;
    localparam int STSR_OUTST_LSB = 16;
    localparam int STSR_LVL_LSB   = 24;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_ADDR   = 4'd1;
    localparam logic [3:0] REG_PUSH   = 4'd2;
    localparam logic [3:0] REG_STS    = 4'd3;
    localparam logic [3:0] REG_ERRCNT = 4'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              eof;
        logic [BTT_W-1:0]  btt;
        logic [TAG_W-1:0]  tag;
    } desc_t;

    function automatic logic [CMD_W-1:0] build_cmd(desc_t d);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_BTT_LSB +: BTT_W]   = d.btt;
        c[CMD_INCR_BIT]           = 1'b1;
        c[CMD_EOF_BIT]            = d.eof;
        c[CMD_ADDR_LSB +: ADDR_W] = d.addr;
        c[CMD_TAG_LSB +: TAG_W]   = d.tag;
        return c;
    endfunction

endpackage

// File: rtl/datamover_cmd_sched_if.sv
// Command and status stream pair between the scheduler (master) and one
// DataMover channel (slave).
interface datamover_cmd_sched_if;
    import dm_sched_pkg::*;

    logic [CMD_W-1:0] m_cmd_tdata;
    logic             m_cmd_tvalid;
    logic             m_cmd_tready;
    logic [STS_W-1:0] s_sts_tdata;
    logic             s_sts_tvalid;
    logic             s_sts_tready;

    modport master (
        output m_cmd_tdata, m_cmd_tvalid,
        input  m_cmd_tready,
        input  s_sts_tdata, s_sts_tvalid,
        output s_sts_tready
    );

    modport slave (
        input  m_cmd_tdata, m_cmd_tvalid,
        output m_cmd_tready,
        output s_sts_tdata, s_sts_tvalid,
        input  s_sts_tready
    );

endinterface

// File: rtl/dm_sched_fifo.sv
// Synchronous FIFO with full/empty/level; DEPTH must be a power of two.
module dm_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // NOTE: storage has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/datamover_cmd_sched.sv
// Descriptor scheduler for one AXI DataMover channel: queues descriptors, issues
// tagged commands, checks status in tag order. Optional watchdog: DM_SCHED_TIMEOUT_EN.
module datamover_cmd_sched
    import dm_sched_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_DESC_DEPTH       = 8,
    parameter int C_STS_DEPTH        = 8,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
    input  logic                          set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
    input  logic                          get_stb,
    output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
    datamover_cmd_sched_if.master         dm,
    output logic                          irq
);
    localparam int         DLW     = $clog2(C_DESC_DEPTH) + 1;
    localparam int         CLW     = $clog2(C_STS_DEPTH) + 1;
    localparam int         COMP_W  = STS_W + 1;
    localparam logic [3:0] MAX_OUT = 4'(C_MAX_OUTSTANDING);

    state_e              state_q;
    logic                enable_q, irq_en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [TAG_W-1:0]    tag_q, exp_tag_q;
    logic [3:0]          outst_q, outst_d;
    logic                err_q, err_d;
    logic [15:0]         errcnt_q, errcnt_d;
    logic                tmo_q, tmo_fire;

    logic [3:0]          set_idx, get_idx;
    logic                wr_ctrl, wr_addr, wr_push, wr_errcnt;
    logic [BTT_W-1:0]    push_btt;
    logic                push_bad;
    logic                desc_push, desc_pop, desc_full, desc_empty;
    desc_t               desc_din, desc_dout;
    logic [DLW-1:0]      desc_level;
    logic                comp_push, comp_pop, comp_full, comp_empty;
    logic [COMP_W-1:0]   comp_din, comp_dout;
    logic [CLW-1:0]      comp_level;
    logic                cmd_hs, sts_hs, sts_take, sts_orphan, sts_bad;
    logic                unused_bits;

    assign set_idx   = set_addr[5:2];
    assign get_idx   = get_addr[5:2];
    assign wr_ctrl   = set_stb && (set_idx == REG_CTRL);
    assign wr_addr   = set_stb && (set_idx == REG_ADDR);
    assign wr_push   = set_stb && (set_idx == REG_PUSH);
    assign wr_errcnt = set_stb && (set_idx == REG_ERRCNT);

    // Zero-length and queue-full pushes are both rejected and flagged.
    assign push_btt  = set_data[BTT_W-1:0];
    assign push_bad  = wr_push && ((push_btt == '0) || desc_full);
    assign desc_push = wr_push && !push_bad;
    assign desc_din  = '{addr: addr_q, eof: set_data[PUSH_EOF_BIT], btt: push_btt, tag: tag_q};
    assign cmd_hs    = (state_q == ST_ISSUE) && dm.m_cmd_tready;
    assign desc_pop  = cmd_hs;

    assign dm.s_sts_tready = !comp_full;
    assign sts_hs     = dm.s_sts_tvalid && dm.s_sts_tready;
    assign sts_orphan = sts_hs && (outst_q == '0);
    assign sts_take   = sts_hs && (outst_q != '0);
    assign sts_bad    = sts_take && ((dm.s_sts_tdata[STS_TAG_LSB +: TAG_W] != exp_tag_q)
                                     || !dm.s_sts_tdata[STS_OKAY_BIT]);
    assign comp_push  = sts_take;
    assign comp_din   = {sts_bad, dm.s_sts_tdata};
    assign comp_pop   = get_stb && (get_idx == REG_STS) && !comp_empty;

    assign irq = irq_en_q && (!comp_empty || err_q);

    dm_sched_fifo #(.WIDTH($bits(desc_t)), .DEPTH(C_DESC_DEPTH)) u_desc_fifo (
        .clk, .rst_n,
        .push_i(desc_push), .din_i(desc_din), .pop_i(desc_pop), .dout_o(desc_dout),
        .full_o(desc_full), .empty_o(desc_empty), .level_o(desc_level)
    );

    dm_sched_fifo #(.WIDTH(COMP_W), .DEPTH(C_STS_DEPTH)) u_comp_fifo (
        .clk, .rst_n,
        .push_i(comp_push), .din_i(comp_din), .pop_i(comp_pop), .dout_o(comp_dout),
        .full_o(comp_full), .empty_o(comp_empty), .level_o(comp_level)
    );

`ifdef DM_SCHED_TIMEOUT_EN
    localparam logic [19:0] TMO_MAX = '1;
    logic [19:0] tmo_cnt_q;

    // Fires once on the transition into the terminal count, which then holds.
    assign tmo_fire = (outst_q != '0) && !sts_hs && (tmo_cnt_q == TMO_MAX - 20'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (sts_hs || (outst_q == '0)) tmo_cnt_q <= '0;
            else if (tmo_cnt_q != TMO_MAX) tmo_cnt_q <= tmo_cnt_q + 20'd1;
            if (wr_errcnt) tmo_q <= 1'b0;
            if (tmo_fire)  tmo_q <= 1'b1;
        end
    end
`else
    assign tmo_q    = 1'b0;
    assign tmo_fire = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        outst_d = outst_q;
        if (cmd_hs && !sts_take)      outst_d = outst_q + 4'd1;
        else if (!cmd_hs && sts_take) outst_d = outst_q - 4'd1;

        err_d    = err_q;
        errcnt_d = errcnt_q;
        if (wr_errcnt) begin
            err_d    = 1'b0;
            errcnt_d = '0;
        end
        if (push_bad || sts_orphan || sts_bad || tmo_fire) err_d = 1'b1;
        if ((sts_bad || tmo_fire) && (errcnt_d != 16'hFFFF)) errcnt_d = errcnt_d + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            addr_q    <= '0;
            tag_q     <= '0;
            exp_tag_q <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
            errcnt_q  <= '0;
        end else begin
            if (wr_ctrl)   {irq_en_q, enable_q} <= set_data[1:0];
            if (wr_addr)   addr_q <= set_data[ADDR_W-1:0];
            if (desc_push) tag_q <= tag_q + 1'b1;
            if (sts_take)  exp_tag_q <= exp_tag_q + 1'b1;
            outst_q  <= outst_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Command data is captured on entry to ISSUE and held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            dm.m_cmd_tvalid <= 1'b0;
            dm.m_cmd_tdata  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (enable_q && !desc_empty && (outst_q < MAX_OUT)) begin
                    dm.m_cmd_tdata  <= build_cmd(desc_dout);
                    dm.m_cmd_tvalid <= 1'b1;
                    state_q         <= ST_ISSUE;
                end
                ST_ISSUE: if (dm.m_cmd_tready) begin
                    dm.m_cmd_tvalid <= 1'b0;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        get_data = '0;
        case (get_idx)
            REG_CTRL:   get_data[1:0] = {irq_en_q, enable_q};
            REG_ADDR:   get_data[ADDR_W-1:0] = addr_q;
            REG_STS: begin
                get_data[STSR_LVL_LSB +: 4]   = 4'(desc_level);
                get_data[STSR_OUTST_LSB +: 4] = outst_q;
                get_data[STSR_TMO_BIT]        = tmo_q;
                get_data[STSR_ERR_BIT]        = err_q || (!comp_empty && comp_dout[STS_W]);
                get_data[STSR_VALID_BIT]      = !comp_empty;
                get_data[STS_W-1:0]           = comp_empty ? '0 : comp_dout[STS_W-1:0];
            end
            REG_ERRCNT: get_data[15:0] = errcnt_q;
            default:    get_data = '0;
        endcase
    end

    assign unused_bits = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:6], set_addr[1:0],
                           get_addr[C_S_AXI_ADDR_WIDTH-1:6], get_addr[1:0], comp_level};

endmodule

// File: tb/tb_datamover_cmd_sched.sv
// Directed, table-driven bench for datamover_cmd_sched (default build, timeout disabled).
module tb_datamover_cmd_sched;

    localparam logic [3:0] R_CTRL = 4'd0, R_ADDR = 4'd1, R_PUSH = 4'd2,
                           R_STS  = 4'd3, R_ERRCNT = 4'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] set_addr = '0, set_data = '0, get_addr = '0;
    logic        set_stb = 1'b0, get_stb = 1'b0;
    logic [31:0] get_data;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    datamover_cmd_sched_if dm_bus ();

    datamover_cmd_sched #(
        .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32),
        .C_DESC_DEPTH(8), .C_STS_DEPTH(8), .C_MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
        .get_addr(get_addr), .get_stb(get_stb), .get_data(get_data),
        .dm(dm_bus), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [3:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [31:0] addr;
        bit          eof;
        logic [22:0] btt;
        logic [71:0] exp;
    } cmd_vec_t;

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic reg_write(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk);
        set_addr = {26'd0, idx, 2'b00};
        set_data = d;
        set_stb  = 1'b1;
        @(posedge clk);
        #1 set_stb = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] idx, input bit pop, output logic [31:0] d);
        @(negedge clk);
        get_addr = {26'd0, idx, 2'b00};
        get_stb  = pop;
        #1 d = get_data;
        @(posedge clk);
        #1 get_stb = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        reg_write(R_PUSH, d);
    endtask

    task automatic send_sts(input logic [7:0] s);
        @(negedge clk);
        check("sts_tready", dm_bus.s_sts_tready, 1);
        dm_bus.s_sts_tvalid = 1'b1;
        dm_bus.s_sts_tdata  = s;
        @(posedge clk);
        #1 dm_bus.s_sts_tvalid = 1'b0;
    endtask

    task automatic wait_tvalid(input string nm);
        int i = 0;
        while (!dm_bus.m_cmd_tvalid && i < 20) begin
            @(negedge clk);
            i++;
        end
        check(nm, dm_bus.m_cmd_tvalid, 1);
    endtask

    task automatic do_reset();
        set_stb = 1'b0; get_stb = 1'b0; set_addr = '0; set_data = '0; get_addr = '0;
        dm_bus.m_cmd_tready = 1'b0;
        dm_bus.s_sts_tvalid = 1'b0;
        dm_bus.s_sts_tdata  = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_vec_t    rv[10];
        cmd_vec_t    cv[3];
        logic [31:0] d;
        int          n_cmd;
        logic [3:0]  last_tag;

        rv[0] = '{1'b1, R_CTRL,   32'hFFFF_FFFF, 32'h0000_0003};
        rv[1] = '{1'b1, R_CTRL,   32'h0000_0002, 32'h0000_0002};
        rv[2] = '{1'b1, R_CTRL,   32'h0000_0000, 32'h0000_0000};
        rv[3] = '{1'b1, R_ADDR,   32'hDEAD_BEEF, 32'hDEAD_BEEF};
        rv[4] = '{1'b1, R_ADDR,   32'h1000_0000, 32'h1000_0000};
        rv[5] = '{1'b0, R_PUSH,   32'h0,         32'h0000_0000};
        rv[6] = '{1'b0, 4'd5,     32'h0,         32'h0000_0000};
        rv[7] = '{1'b0, 4'd15,    32'h0,         32'h0000_0000};
        rv[8] = '{1'b0, R_ERRCNT, 32'h0,         32'h0000_0000};
        rv[9] = '{1'b1, R_ERRCNT, 32'h0000_1234, 32'h0000_0000};

        cv[0] = '{32'h0000_0000, 1'b0, 23'h7F_FFFF, 72'h0_1_00000000_00FFFFFF};
        cv[1] = '{32'hFFFF_FFFC, 1'b1, 23'h00_0001, 72'h0_2_FFFFFFFC_40800001};
        cv[2] = '{32'h8000_1234, 1'b0, 23'h00_0100, 72'h0_3_80001234_00800100};

        // Reset state
        do_reset();
        check("rst_tvalid", dm_bus.m_cmd_tvalid, 0);
        check("rst_tdata", dm_bus.m_cmd_tdata, 0);
        check("rst_irq", irq, 0);
        reg_read(R_STS, 1'b0, d);  check("rst_sts", d, 0);
        reg_read(R_CTRL, 1'b0, d); check("rst_ctrl", d, 0);

        // Register map table
        for (int i = 0; i < 10; i++) begin
            if (rv[i].wr) reg_write(rv[i].idx, rv[i].wdata);
            reg_read(rv[i].idx, 1'b0, d);
            check($sformatf("reg_vec%0d", i), d, rv[i].exp);
        end

        // First command: held under backpressure, single pop on handshake
        push(32'h4000_0040);
        reg_read(R_STS, 1'b0, d); check("lvl_before_issue", d[27:24], 1);
        reg_write(R_CTRL, 32'h1);
        wait_tvalid("first_tvalid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold_tvalid%0d", i), dm_bus.m_cmd_tvalid, 1);
            check($sformatf("hold_tdata%0d", i), dm_bus.m_cmd_tdata, 72'h0_0_10000000_40800040);
        end
        check("irq_disabled", irq, 0);
        @(negedge clk); dm_bus.m_cmd_tready = 1'b1;
        @(posedge clk); #1 dm_bus.m_cmd_tready = 1'b0;
        repeat (4) @(negedge clk);
        check("tvalid_after_hs", dm_bus.m_cmd_tvalid, 0);
        reg_read(R_STS, 1'b0, d); check("sts_after_issue", d, 32'h0001_0000);
        send_sts(8'h80);
        reg_read(R_STS, 1'b1, d); check("sts_first_done", d, 32'h0000_0180);
        reg_read(R_STS, 1'b0, d); check("sts_after_pop", d, 0);

        // Command word table, tags 1..3
        dm_bus.m_cmd_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reg_write(R_ADDR, cv[i].addr);
            push({1'b0, cv[i].eof, 7'd0, cv[i].btt});
            wait_tvalid($sformatf("cmd_vec%0d_tvalid", i));
            check($sformatf("cmd_vec%0d_tdata", i), dm_bus.m_cmd_tdata, cv[i].exp);
            @(posedge clk); #1;
            send_sts(8'h80 | 8'(i + 1));
            reg_read(R_STS, 1'b1, d);
            check($sformatf("cmd_vec%0d_sts", i), d, 32'h0000_0180 | 32'(i + 1));
        end

        // Outstanding limit
        do_reset();
        for (int i = 0; i < 6; i++) push(32'h0000_0100 + 32'(i));
        dm_bus.m_cmd_tready = 1'b1;
        reg_write(R_CTRL, 32'h1);
        n_cmd = 0;
        repeat (40) begin
            @(negedge clk);
            if (dm_bus.m_cmd_tvalid) n_cmd++;
        end
        check("outst_limit_cmds", n_cmd, 4);
        reg_read(R_STS, 1'b0, d);
        check("outst_limit_outst", d[19:16], 4);
        check("outst_limit_lvl", d[27:24], 2);
        send_sts(8'h80);
        n_cmd = 0;
        last_tag = '0;
        repeat (40) begin
            @(negedge clk);
            if (dm_bus.m_cmd_tvalid) begin
                n_cmd++;
                last_tag = dm_bus.m_cmd_tdata[67:64];
            end
        end
        check("fifth_cmd_count", n_cmd, 1);
        check("fifth_cmd_tag", last_tag, 4);
        for (int i = 1; i < 6; i++) send_sts(8'h80 | 8'(i));
        repeat (2) @(negedge clk);
        reg_read(R_STS, 1'b0, d); check("drain_sts_head", d, 32'h0000_0180);
        for (int i = 0; i < 6; i++) begin
            reg_read(R_STS, 1'b1, d);
            check($sformatf("comp_pop%0d", i), d, 32'h0000_0180 | 32'(i));
        end
        reg_read(R_STS, 1'b0, d); check("comp_empty", d, 0);

        // Issue and status in the same cycle leave outst unchanged
        dm_bus.m_cmd_tready = 1'b0;
        reg_write(R_CTRL, 32'h0);
        push(32'h0000_0010);
        push(32'h0000_0020);
        reg_write(R_CTRL, 32'h1);
        wait_tvalid("same_cyc_tvalid0");
        check("same_cyc_tag6", dm_bus.m_cmd_tdata[67:64], 6);
        @(negedge clk); dm_bus.m_cmd_tready = 1'b1;
        @(posedge clk); #1 dm_bus.m_cmd_tready = 1'b0;
        wait_tvalid("same_cyc_tvalid1");
        @(negedge clk);
        dm_bus.m_cmd_tready = 1'b1;
        dm_bus.s_sts_tvalid = 1'b1;
        dm_bus.s_sts_tdata  = 8'h86;
        @(posedge clk);
        #1 dm_bus.m_cmd_tready = 1'b0;
        dm_bus.s_sts_tvalid = 1'b0;
        reg_read(R_STS, 1'b0, d); check("same_cyc_outst", d[19:16], 1);
        send_sts(8'h87);
        reg_read(R_STS, 1'b0, d);
        check("same_cyc_outst_end", d[19:16], 0);
        check("same_cyc_no_err", d[9], 0);

        // Tag mismatch, orphan status, SLVERR
        do_reset();
        reg_write(R_ADDR, 32'h3000_0000);
        push(32'h0000_0100);
        dm_bus.m_cmd_tready = 1'b1;
        reg_write(R_CTRL, 32'h3);
        wait_tvalid("err_tvalid");
        @(posedge clk); #1;
        @(negedge clk); check("irq_idle", irq, 0);
        send_sts(8'h82);
        @(negedge clk); check("irq_on_err", irq, 1);
        reg_read(R_STS, 1'b0, d);   check("tag_mismatch_sts", d, 32'h0000_0382);
        reg_read(R_ERRCNT, 1'b0, d); check("errcnt_one", d, 1);
        reg_read(R_STS, 1'b1, d);
        @(negedge clk); check("irq_err_sticky", irq, 1);
        reg_write(R_ERRCNT, 32'h0);
        reg_read(R_ERRCNT, 1'b0, d); check("errcnt_cleared", d, 0);
        @(negedge clk); check("irq_cleared", irq, 0);
        send_sts(8'h81);
        reg_read(R_STS, 1'b0, d); check("orphan_sts", d, 32'h0000_0200);
        reg_write(R_ERRCNT, 32'h0);
        push(32'h0000_0008);
        wait_tvalid("slverr_tvalid");
        check("slverr_tag1", dm_bus.m_cmd_tdata[67:64], 1);
        @(posedge clk); #1;
        send_sts(8'h41);
        reg_read(R_STS, 1'b0, d);    check("slverr_sts", d, 32'h0000_0341);
        reg_read(R_ERRCNT, 1'b0, d); check("slverr_errcnt", d, 1);
        reg_write(R_CTRL, 32'h1);
        @(negedge clk); check("irq_masked", irq, 0);

        // Zero-length push, full descriptor queue
        do_reset();
        reg_write(R_ADDR, 32'h2000_0000);
        push(32'h4000_0000);
        reg_read(R_STS, 1'b0, d); check("btt0_dropped", d, 32'h0000_0200);
        reg_write(R_ERRCNT, 32'h0);
        for (int i = 0; i < 8; i++) push(32'h0000_0010 + 32'(i));
        reg_read(R_STS, 1'b0, d); check("desc_full8", d, 32'h0800_0000);
        push(32'h0000_0099);
        reg_read(R_STS, 1'b0, d); check("desc_overflow", d, 32'h0800_0200);

        // Reset during ISSUE
        reg_write(R_CTRL, 32'h1);
        wait_tvalid("pre_rst_tvalid");
        check("pre_rst_tdata", dm_bus.m_cmd_tdata, 72'h0_0_20000000_00800010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", dm_bus.m_cmd_tvalid, 0);
        check("async_rst_tdata", dm_bus.m_cmd_tdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        reg_read(R_STS, 1'b0, d);  check("post_rst_sts", d, 0);
        reg_read(R_ADDR, 1'b0, d); check("post_rst_addr", d, 0);
        push(32'h0000_0020);
        reg_write(R_CTRL, 32'h1);
        wait_tvalid("post_rst_tvalid");
        check("post_rst_tag0", dm_bus.m_cmd_tdata, 72'h0_0_00000000_00800020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
